// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register: owns the PC, squashes wrong-path fetches on taken
// branches, freezes on stall, and stops the front end on HLT so the pipeline drains.
module fetch_stage #(
   parameter int unsigned          DATA_W     = 16,
   parameter logic [DATA_W-1:0]    RESET_PC   = 16'h0000,
   parameter logic [DATA_W-1:0]    NOP_INSTR  = 16'h0000,
   parameter logic [3:0]           HLT_OPCODE = 4'hF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [DATA_W-1:0] branch_target,
   input  logic [DATA_W-1:0] imem_data,
   output logic [DATA_W-1:0] imem_addr,
   output logic [DATA_W-1:0] IFID_instr,
   output logic [DATA_W-1:0] IFID_pc,
   output logic [DATA_W-1:0] IFID_pc_plus2,
   output logic              IFID_valid,
   output logic              fetch_halted
);

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [DATA_W-1:0] ifpc_q, ifpc_d;
   logic [DATA_W-1:0] ifpc2_q, ifpc2_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] pc_plus2;
   logic              is_hlt;

   assign pc_plus2 = pc_q + DATA_W'(2);
   assign is_hlt   = (imem_data[DATA_W-1 -: 4] == HLT_OPCODE);

   // Stall is tested first so an undefined imem_data during a stall cannot reach any state.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ifpc_d  = ifpc_q;
      ifpc2_d = ifpc2_q;
      valid_d = valid_q;
      unique case (state_q)
         S_RUN: begin
            if (stall) begin
               // hold everything; ID re-asserts any branch once the stall clears
            end else if (branch_taken) begin
               pc_d    = branch_target;
               instr_d = NOP_INSTR;
               valid_d = 1'b0;
            end else if (is_hlt) begin
               instr_d = imem_data;
               ifpc_d  = pc_q;
               ifpc2_d = pc_plus2;
               valid_d = 1'b1;
               state_d = S_HALT;
            end else begin
               instr_d = imem_data;
               ifpc_d  = pc_q;
               ifpc2_d = pc_plus2;
               valid_d = 1'b1;
               pc_d    = pc_plus2;
            end
         end
         S_HALT: begin
            if (!stall) begin
               instr_d = NOP_INSTR;
               valid_d = 1'b0;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RUN;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         ifpc_q  <= '0;
         ifpc2_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ifpc_q  <= ifpc_d;
         ifpc2_q <= ifpc2_d;
         valid_q <= valid_d;
      end
   end

   assign imem_addr     = pc_q;
   assign IFID_instr    = instr_q;
   assign IFID_pc       = ifpc_q;
   assign IFID_pc_plus2 = ifpc2_q;
   assign IFID_valid    = valid_q;
   assign fetch_halted  = (state_q == S_HALT);

endmodule
